linear_layer_tiled: RTL and testbench

Parametrised successor to linear_layer. It computes out[m] = requant(bias[m] + sum_k act[k]*W[m][k]) for M outputs, using LANES parallel MAC lanes so that LANES outputs are produced per group. Weights are streamed from a near-memory weight bank through a 1-cycle-latency read port. Results leave as a LANES-wide word on a valid/ready stream, with optional ReLU, arithmetic right shift and saturation to OUT_WIDTH.

---
 rtl/linear_pkg.sv | 29 ++
 rtl/mac_lane.sv | 63 ++++++
 rtl/linear_layer_tiled.sv | 193 +++++++++++++++++++
 tb/tb_linear_layer_tiled.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/linear_pkg.sv
// Shared FSM encodings, width helper and requant saturation bounds for the tiled linear layer.
package linear_pkg;

  localparam int unsigned STATE_WIDTH = 3;

  localparam logic [STATE_WIDTH-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_WIDTH-1:0] ST_LOAD  = 3'd1;
  localparam logic [STATE_WIDTH-1:0] ST_FETCH = 3'd2;
  localparam logic [STATE_WIDTH-1:0] ST_DRAIN = 3'd3;
  localparam logic [STATE_WIDTH-1:0] ST_OUT   = 3'd4;
  localparam logic [STATE_WIDTH-1:0] ST_DONE  = 3'd5;

  // Ceil log2, never below 1 so single-entry indices still get a real bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(value)) r = r + 1;
    return r;
  endfunction

  function automatic longint sat_max(input int unsigned width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int unsigned width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed MAC accumulator with bias load and combinational ReLU/shift/saturate requant.
module mac_lane
  import linear_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned W_WIDTH     = 8,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   acc_en,
  input  logic [ACC_WIDTH-1:0]   bias,
  input  logic [DATA_WIDTH-1:0]  act,
  input  logic [W_WIDTH-1:0]     weight,
  input  logic                   relu_en,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic [OUT_WIDTH-1:0]   result_c
);

  localparam int unsigned PROD_WIDTH = DATA_WIDTH + W_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(sat_min(OUT_WIDTH));

  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [PROD_WIDTH-1:0] prod_c;
  logic signed [ACC_WIDTH-1:0]  relu_c;
  logic signed [ACC_WIDTH-1:0]  shifted_c;
  logic signed [ACC_WIDTH-1:0]  sat_c;

  assign prod_c = PROD_WIDTH'($signed(act)) * PROD_WIDTH'($signed(weight));

  // Accumulator wraps modulo 2^ACC_WIDTH by design.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= $signed(bias);
    end else if (acc_en) begin
      acc <= acc + ACC_WIDTH'(prod_c);
    end
  end

  always_comb begin
    relu_c = (relu_en && acc[ACC_WIDTH-1]) ? '0 : acc;
    if (32'(shift) >= 32'(ACC_WIDTH)) begin
      shifted_c = relu_c[ACC_WIDTH-1] ? '1 : '0;
    end else begin
      shifted_c = relu_c >>> shift;
    end
    if (shifted_c > SAT_HI) begin
      sat_c = SAT_HI;
    end else if (shifted_c < SAT_LO) begin
      sat_c = SAT_LO;
    end else begin
      sat_c = shifted_c;
    end
    result_c = OUT_WIDTH'(sat_c);
  end

endmodule

// File: rtl/linear_layer_tiled.sv
// Tiled linear layer: LANES MAC lanes per group, weights streamed from a 1-cycle bank,
// requantised results leave per group on a valid/ready stream.
module linear_layer_tiled
  import linear_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned W_WIDTH     = 8,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned N           = 16,
  parameter int unsigned M           = 12,
  parameter int unsigned LANES       = 4,
  parameter int unsigned SHIFT_WIDTH = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                relu_en,
  input  logic [SHIFT_WIDTH-1:0]              shift,
  input  logic [N*DATA_WIDTH-1:0]             act_data,
  input  logic [M*ACC_WIDTH-1:0]              bias_data,
  output logic                                w_rd_en,
  output logic [clog2((M/LANES)*N)-1:0]       w_addr,
  input  logic [LANES*W_WIDTH-1:0]            w_rdata,
  output logic [LANES*OUT_WIDTH-1:0]          out_data,
  output logic [clog2(M/LANES)-1:0]           out_group,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned G  = M / LANES;
  localparam int unsigned AW = clog2(G * N);
  localparam int unsigned GW = clog2(G);
  localparam int unsigned KW = clog2(N);

  logic [STATE_WIDTH-1:0] state, state_d;
  logic [GW-1:0]          group_idx, group_d;
  logic [KW-1:0]          tap_idx, tap_d;
  logic                   rd_d;
  logic [AW-1:0]          addr_d;
  logic                   valid_d, busy_d, done_d;
  logic                   capture_c, load_c, out_load_c;

  logic                         mac_en;
  logic [KW-1:0]                mac_tap;
  logic [N*DATA_WIDTH-1:0]      act_q;
  logic [M*ACC_WIDTH-1:0]       bias_q;
  logic                         relu_q;
  logic [SHIFT_WIDTH-1:0]       shift_q;
  logic [DATA_WIDTH-1:0]        mac_act_c;
  logic [LANES*OUT_WIDTH-1:0]   lane_res_c;

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state;
    group_d    = group_idx;
    tap_d      = tap_idx;
    rd_d       = 1'b0;
    addr_d     = w_addr;
    valid_d    = out_valid;
    busy_d     = busy;
    done_d     = 1'b0;
    capture_c  = 1'b0;
    load_c     = 1'b0;
    out_load_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          capture_c = 1'b1;
          group_d   = '0;
          busy_d    = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_c  = 1'b1;
        tap_d   = '0;
        rd_d    = 1'b1;
        addr_d  = AW'(32'(group_idx) * N);
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (tap_idx == KW'(N - 1)) begin
          state_d = ST_DRAIN;
        end else begin
          tap_d  = tap_idx + KW'(1);
          rd_d   = 1'b1;
          addr_d = w_addr + AW'(1);
        end
      end
      ST_DRAIN: begin
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (!out_valid) begin
          out_load_c = 1'b1;
          valid_d    = 1'b1;
        end else if (out_ready) begin
          valid_d = 1'b0;
          if (group_idx == GW'(G - 1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            group_d = group_idx + GW'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      group_idx <= '0;
      tap_idx   <= '0;
      w_rd_en   <= 1'b0;
      w_addr    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      group_idx <= group_d;
      tap_idx   <= tap_d;
      w_rd_en   <= rd_d;
      w_addr    <= addr_d;
      out_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // MAC stage trails the read issue by one cycle to match the bank latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_en    <= 1'b0;
      mac_tap   <= '0;
      act_q     <= '0;
      bias_q    <= '0;
      relu_q    <= 1'b0;
      shift_q   <= '0;
      out_data  <= '0;
      out_group <= '0;
    end else begin
      mac_en  <= w_rd_en;
      mac_tap <= tap_idx;
      if (capture_c) begin
        act_q   <= act_data;
        bias_q  <= bias_data;
        relu_q  <= relu_en;
        shift_q <= shift;
      end
      if (out_load_c) begin
        out_data  <= lane_res_c;
        out_group <= group_idx;
      end
    end
  end

  assign mac_act_c = act_q[32'(mac_tap) * DATA_WIDTH +: DATA_WIDTH];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .W_WIDTH     (W_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH),
      .OUT_WIDTH   (OUT_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_c),
      .acc_en   (mac_en),
      .bias     (bias_q[(32'(group_idx) * LANES + l) * ACC_WIDTH +: ACC_WIDTH]),
      .act      (mac_act_c),
      .weight   (w_rdata[l * W_WIDTH +: W_WIDTH]),
      .relu_en  (relu_q),
      .shift    (shift_q),
      .result_c (lane_res_c[l * OUT_WIDTH +: OUT_WIDTH])
    );
  end

endmodule

// File: tb/tb_linear_layer_tiled.sv
// Bench for linear_layer_tiled with N=4, M=4, LANES=2: vector table plus backpressure,
// mid-run start and mid-run reset sequences, scored through an expected-output queue.
module tb_linear_layer_tiled;

  localparam int unsigned N = 4;

  typedef logic [3:0][7:0]  b4_t;
  typedef logic [3:0][31:0] w4_t;

  typedef struct packed {
    b4_t             act;
    logic [3:0][3:0][7:0] w;
    w4_t             bias;
    logic [4:0]      shift;
    logic            relu;
    b4_t             exp;
  } vec_t;

  typedef struct packed {
    logic [0:0]  grp;
    logic [15:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n, start, relu_en, out_ready;
  logic [4:0]  shift;
  logic [31:0] act_data;
  logic [127:0] bias_data;
  logic        w_rd_en;
  logic [2:0]  w_addr;
  logic [15:0] w_rdata = '0;
  logic [15:0] out_data;
  logic [0:0]  out_group;
  logic        out_valid, busy, done;

  vec_t vecs[9];
  vec_t cur = '0;
  sb_t  sbq[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc_cnt = 0;
  int   last_hs = 0;
  logic stall_prev = 1'b0;
  logic [15:0] data_prev = '0;
  logic [0:0]  grp_prev = '0;

  always #5 clk = ~clk;

  linear_layer_tiled #(
    .DATA_WIDTH (8), .W_WIDTH (8), .ACC_WIDTH (32), .OUT_WIDTH (8),
    .N (4), .M (4), .LANES (2), .SHIFT_WIDTH (5)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .relu_en (relu_en), .shift (shift),
    .act_data (act_data), .bias_data (bias_data), .w_rd_en (w_rd_en), .w_addr (w_addr),
    .w_rdata (w_rdata), .out_data (out_data), .out_group (out_group),
    .out_valid (out_valid), .out_ready (out_ready), .busy (busy), .done (done)
  );

  function automatic b4_t mk4(input int a0, input int a1, input int a2, input int a3);
    b4_t r;
    r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
    return r;
  endfunction

  function automatic w4_t mkb(input int a0, input int a1, input int a2, input int a3);
    w4_t r;
    r[0] = 32'(a0); r[1] = 32'(a1); r[2] = 32'(a2); r[3] = 32'(a3);
    return r;
  endfunction

  task automatic set_vec(input int i, input b4_t act, input b4_t w0, input b4_t w1,
                         input b4_t w2, input b4_t w3, input w4_t bias, input int sh,
                         input bit relu, input b4_t exp);
    vecs[i].act  = act;
    vecs[i].w[0] = w0; vecs[i].w[1] = w1; vecs[i].w[2] = w2; vecs[i].w[3] = w3;
    vecs[i].bias = bias;
    vecs[i].shift = 5'(sh);
    vecs[i].relu = relu;
    vecs[i].exp  = exp;
  endtask

  task automatic check(input string name, input longint actv, input longint expv);
    n_cmp++;
    if (actv != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actv, expv, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Weight bank model: one-cycle read latency.
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (w_rd_en) begin
      w_rdata <= {cur.w[2 * (int'(w_addr) / N) + 1][int'(w_addr) % N],
                  cur.w[2 * (int'(w_addr) / N)][int'(w_addr) % N]};
    end
  end

  // Output monitor: pops expected words on handshake and checks hold during stalls.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (stall_prev) begin
        check("stall_data_hold", longint'(out_data), longint'(data_prev));
        check("stall_group_hold", longint'(out_group), longint'(grp_prev));
      end
      if (!out_ready) check("stall_no_read", longint'(w_rd_en), 0);
      if (out_ready) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got data %h group %0d with nothing expected", out_data, out_group);
        end else begin
          check("out_group", longint'(out_group), longint'(sbq[0].grp));
          check("out_data", longint'(out_data), longint'(sbq[0].data));
          void'(sbq.pop_front());
        end
        last_hs = cyc_cnt;
      end
    end
    stall_prev = rst_n && out_valid && !out_ready;
    data_prev  = out_data;
    grp_prev   = out_group;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_w_rd_en"}, longint'(w_rd_en), 0);
    check({tag, "_w_addr"}, longint'(w_addr), 0);
    check({tag, "_out_data"}, longint'(out_data), 0);
    check({tag, "_out_group"}, longint'(out_group), 0);
    check({tag, "_out_valid"}, longint'(out_valid), 0);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
  endtask

  task automatic apply_vec(input int idx);
    cur       = vecs[idx];
    act_data  = vecs[idx].act;
    bias_data = vecs[idx].bias;
    relu_en   = vecs[idx].relu;
    shift     = vecs[idx].shift;
  endtask

  // mode 0: plain run, 1: five-cycle stall on group 0, 2: extra start pulse while busy
  task automatic run_vector(input int idx, input int mode);
    int  cyc;
    sb_t e;
    apply_vec(idx);
    out_ready = (mode != 1);
    e.grp = 1'b0; e.data = {vecs[idx].exp[1], vecs[idx].exp[0]};
    sbq.push_back(e);
    e.grp = 1'b1; e.data = {vecs[idx].exp[3], vecs[idx].exp[2]};
    sbq.push_back(e);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_after_start", longint'(busy), 1);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      if (mode == 2 && cyc == 2) begin
        start     = 1'b1;
        act_data  = 32'hdead_beef;
        bias_data = {4{32'h8000_0001}};
        relu_en   = ~vecs[idx].relu;
        shift     = 5'd7;
      end else begin
        start = 1'b0;
      end
      tick;
      cyc++;
    end
    start = 1'b0;
    check("first_valid_latency", cyc, N + 3);
    if (mode == 1) begin
      repeat (5) begin
        tick;
        check("stall_valid_held", longint'(out_valid), 1);
      end
      out_ready = 1'b1;
    end
    cyc = 0;
    while (!done && cyc < 60) begin
      tick;
      cyc++;
    end
    check("done_seen", longint'(done), 1);
    check("done_after_handshake", cyc_cnt - last_hs, 1);
    check("busy_low_at_done", longint'(busy), 0);
    tick;
    check("done_one_cycle", longint'(done), 0);
    check("scoreboard_drained", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; relu_en = 1'b0; shift = '0;
    act_data = '0; bias_data = '0; out_ready = 1'b1;

    set_vec(0, mk4(1, 2, -1, 3), mk4(1, 1, 1, 1), mk4(2, 2, 2, 2), mk4(3, 3, 3, 3), mk4(4, 4, 4, 4),
            mkb(10, 20, 30, 40), 0, 1'b0, mk4(15, 30, 45, 60));
    set_vec(1, mk4(1, 2, -1, 3), mk4(1, 0, 0, 0), mk4(0, 1, 0, 0), mk4(0, 0, 1, 0), mk4(0, 0, 0, 1),
            mkb(0, 0, 0, 0), 0, 1'b0, mk4(1, 2, -1, 3));
    set_vec(2, mk4(1, 2, -1, 3), mk4(1, 0, 0, 0), mk4(0, 1, 0, 0), mk4(0, 0, 1, 0), mk4(0, 0, 0, 1),
            mkb(0, 0, 0, 0), 0, 1'b1, mk4(1, 2, 0, 3));
    set_vec(3, mk4(127, 127, 127, 127), mk4(127, 127, 127, 127), mk4(127, 127, 127, 127),
            mk4(127, 127, 127, 127), mk4(127, 127, 127, 127),
            mkb(0, 0, 0, 0), 4, 1'b0, mk4(127, 127, 127, 127));
    set_vec(4, mk4(127, 127, 127, 127), mk4(-128, -128, -128, -128), mk4(-128, -128, -128, -128),
            mk4(-128, -128, -128, -128), mk4(-128, -128, -128, -128),
            mkb(0, 0, 0, 0), 4, 1'b0, mk4(-128, -128, -128, -128));
    set_vec(5, mk4(1, 2, -1, 3), mk4(0, 0, 0, 0), mk4(0, 0, 0, 0), mk4(0, 0, 0, 0), mk4(0, 0, 0, 0),
            mkb(-7, -7, -7, -7), 1, 1'b0, mk4(-4, -4, -4, -4));
    set_vec(6, mk4(1, 2, -1, 3), mk4(0, 0, 0, 0), mk4(0, 0, 0, 0), mk4(0, 0, 0, 0), mk4(0, 0, 0, 0),
            mkb(-100, 100, -1, 2147483647), 31, 1'b0, mk4(-1, 0, -1, 0));
    set_vec(7, mk4(1, 0, 0, 0), mk4(1, 0, 0, 0), mk4(0, 0, 0, 0), mk4(0, 0, 0, 0), mk4(0, 0, 0, 0),
            mkb(2147483647, 0, 0, 0), 0, 1'b0, mk4(-128, 0, 0, 0));
    set_vec(8, mk4(3, -2, 5, -1), mk4(1, -1, 2, 0), mk4(0, 0, 0, 1), mk4(-3, 1, 1, 4), mk4(2, 2, 2, 2),
            mkb(1, -1, 100, -20), 1, 1'b1, mk4(8, 0, 45, 0));

    #12;
    check_all_zero("reset");
    tick;
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 9; i++) run_vector(i, 0);
    run_vector(0, 1);
    run_vector(0, 2);

    // Abort a run with reset while weights are being fetched.
    apply_vec(0);
    out_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    check("fetch_before_reset", longint'(w_rd_en), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    repeat (3) begin
      tick;
      check("no_done_in_reset", longint'(done), 0);
    end
    rst_n = 1'b1;
    repeat (10) begin
      tick;
      check("no_done_after_reset", longint'(done), 0);
      check("idle_after_reset", longint'(busy), 0);
    end

    run_vector(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
